// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with enable and a timed auto-scan mode.
// Each scan line is held for DWELL cycles; step/wrap pulse when the index advances.
module decoder_scan #(
   parameter int N          = 2,
   parameter int DWELL      = 4,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                mode,
   input  logic [N-1:0]        addr,
   input  logic                load,
   output logic [(1<<N)-1:0]   D,
   output logic [N-1:0]        idx,
   output logic                step,
   output logic                wrap
);

   localparam int W  = 1 << N;
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);
   localparam logic [N-1:0]  IDX_MAX = '1;
   localparam logic [W-1:0]  ONE     = W'(1);

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [N-1:0]    idx_nxt;
   logic            step_nxt;
   logic            wrap_nxt;
   logic            act;
   logic [W-1:0]    lines;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_OFF;
         idx   <= '0;
         cnt   <= '0;
         act   <= 1'b0;
         step  <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         cnt   <= cnt_nxt;
         act   <= en;
         step  <= step_nxt;
         wrap  <= wrap_nxt;
      end
   end

   // The edge that enters SCAN keeps cnt at 0, so the first line lasts a full DWELL.
   always_comb begin
      state_nxt = ST_OFF;
      idx_nxt   = idx;
      cnt_nxt   = '0;
      step_nxt  = 1'b0;
      wrap_nxt  = 1'b0;
      if (!en) begin
         state_nxt = ST_OFF;
      end else if (!mode) begin
         state_nxt = ST_DIRECT;
         idx_nxt   = addr;
      end else begin
         state_nxt = ST_SCAN;
         if (load) begin
            idx_nxt = addr;
         end else if (state != ST_SCAN) begin
            cnt_nxt = '0;
         end else if (cnt == CNT_MAX) begin
            idx_nxt  = idx + 1'b1;
            step_nxt = 1'b1;
            wrap_nxt = (idx == IDX_MAX);
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

   assign lines = act ? (ONE << idx) : '0;
   assign D     = (ACTIVE_LOW != 0) ? ~lines : lines;

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: direct decode, scan timing, load/enable/mode
// interactions and asynchronous reset, with an active-low and an N=3/DWELL=1 instance.
module tb_decoder_scan;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       mode;
   logic [1:0] addr;
   logic [2:0] addr3;
   logic       load;

   logic [3:0] d;
   logic [1:0] idx;
   logic       step;
   logic       wrap;
   logic [3:0] d_al;
   logic [1:0] idx_al;
   logic       step_al;
   logic       wrap_al;
   logic [7:0] d3;
   logic [2:0] idx3;
   logic       step3;
   logic       wrap3;

   int errors = 0;
   int checks = 0;

   logic [7:0]  exp_q[$];
   logic [12:0] exp3_q[$];

   decoder_scan #(.N(2), .DWELL(4), .ACTIVE_LOW(0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr), .load(load),
      .D(d), .idx(idx), .step(step), .wrap(wrap)
   );

   decoder_scan #(.N(2), .DWELL(4), .ACTIVE_LOW(1)) dut_al (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr), .load(load),
      .D(d_al), .idx(idx_al), .step(step_al), .wrap(wrap_al)
   );

   decoder_scan #(.N(3), .DWELL(1), .ACTIVE_LOW(0)) dut3 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr3), .load(load),
      .D(d3), .idx(idx3), .step(step3), .wrap(wrap3)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver: set inputs, take one rising edge, return 1 time unit after it
   task automatic apply(input logic e, input logic m, input logic [1:0] a, input logic l);
      en   = e;
      mode = m;
      addr = a;
      load = l;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] obs;
      rst_n = 1'b0;
      en    = 1'b1;
      mode  = 1'b0;
      addr  = 2'd2;
      load  = 1'b0;
      addr3 = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      obs = {step, wrap, idx, d};
      checks++;
      if (obs !== 8'h00) begin
         errors++;
         $display("FAIL reset_main: got %b expected %b", obs, 8'h00);
      end
      checks++;
      if (d_al !== 4'b1111) begin
         errors++;
         $display("FAIL reset_active_low: got %b expected %b", d_al, 4'b1111);
      end
      checks++;
      if ({step3, wrap3, idx3, d3} !== 13'h0) begin
         errors++;
         $display("FAIL reset_n3: got %b expected %b", {step3, wrap3, idx3, d3}, 13'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      apply(1'b1, 1'b0, 2'd2, 1'b0);
      obs = {step, wrap, idx, d};
      checks++;
      if (obs !== {1'b0, 1'b0, 2'd2, 4'b0100}) begin
         errors++;
         $display("FAIL reset_release_direct: got %b expected %b", obs, {1'b0, 1'b0, 2'd2, 4'b0100});
      end
      checks++;
      if (d_al !== 4'b1011) begin
         errors++;
         $display("FAIL reset_release_al: got %b expected %b", d_al, 4'b1011);
      end
   endtask

   task automatic test_direct();
      logic [7:0] e;
      logic [3:0] oh;
      logic [1:0] a;
      for (int i = 0; i < 4; i++) begin
         a  = i[1:0];
         oh = 4'b0001 << a;
         exp_q.push_back({1'b0, 1'b0, a, oh});
      end
      for (int i = 0; i < 4; i++) begin
         a = i[1:0];
         apply(1'b1, 1'b0, a, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if ({step, wrap, idx, d} !== e) begin
            errors++;
            $display("FAIL direct addr=%0d: got %b expected %b", i, {step, wrap, idx, d}, e);
         end
         checks++;
         if ({step_al, wrap_al, idx_al, ~d_al} !== e) begin
            errors++;
            $display("FAIL direct_al addr=%0d: got D=%b expected D=%b", i, d_al, ~e[3:0]);
         end
      end
   endtask

   task automatic test_scan_wrap();
      logic [7:0] e;
      logic [3:0] oh;
      int c;
      int li;
      int steps;
      int wraps;
      logic stp;
      logic wr;
      exp_q.push_back({1'b0, 1'b0, 2'd3, 4'b1000});
      for (int s = 0; s < 16; s++) begin
         c   = (s + 1) % 4;
         li  = (3 + (s + 1) / 4) % 4;
         stp = (c == 0);
         wr  = stp && (li == 0);
         oh  = 4'b0001 << li;
         exp_q.push_back({stp, wr, li[1:0], oh});
      end
      steps = 0;
      wraps = 0;
      for (int s = 0; s < 17; s++) begin
         if (s == 0) apply(1'b1, 1'b1, 2'd3, 1'b1);
         else        apply(1'b1, 1'b1, 2'd0, 1'b0);
         if (step) steps++;
         if (wrap) wraps++;
         e = exp_q.pop_front();
         checks++;
         if ({step, wrap, idx, d} !== e) begin
            errors++;
            $display("FAIL scan_wrap cycle %0d: got %b expected %b", s, {step, wrap, idx, d}, e);
         end
      end
      checks++;
      if (steps !== 4 || wraps !== 1) begin
         errors++;
         $display("FAIL scan_sweep_pulses: got steps=%0d wraps=%0d expected steps=4 wraps=1", steps, wraps);
      end
   endtask

   task automatic test_load_collide();
      logic [7:0] e;
      for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 1'b0, 2'd3, 4'b1000});
      exp_q.push_back({1'b0, 1'b0, 2'd1, 4'b0010});
      for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 1'b0, 2'd1, 4'b0010});
      exp_q.push_back({1'b1, 1'b0, 2'd2, 4'b0100});
      for (int i = 0; i < 8; i++) begin
         if (i == 3) apply(1'b1, 1'b1, 2'd1, 1'b1);
         else        apply(1'b1, 1'b1, 2'd0, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if ({step, wrap, idx, d} !== e) begin
            errors++;
            $display("FAIL load_collide cycle %0d: got %b expected %b", i, {step, wrap, idx, d}, e);
         end
      end
   endtask

   task automatic test_enable_gap();
      logic [7:0] e;
      exp_q.push_back({1'b0, 1'b0, 2'd2, 4'b0100});
      exp_q.push_back({1'b0, 1'b0, 2'd2, 4'b0000});
      exp_q.push_back({1'b0, 1'b0, 2'd2, 4'b0000});
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 1'b0, 2'd2, 4'b0100});
      exp_q.push_back({1'b1, 1'b0, 2'd3, 4'b1000});
      for (int i = 0; i < 8; i++) begin
         apply((i == 1 || i == 2) ? 1'b0 : 1'b1, 1'b1, 2'd0, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if ({step, wrap, idx, d} !== e) begin
            errors++;
            $display("FAIL enable_gap cycle %0d: got %b expected %b", i, {step, wrap, idx, d}, e);
         end
      end
   endtask

   task automatic test_mode_switch();
      logic [7:0] e;
      for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 1'b0, 2'd1, 4'b0010});
      exp_q.push_back({1'b1, 1'b0, 2'd2, 4'b0100});
      for (int i = 0; i < 6; i++) begin
         if (i == 0) apply(1'b1, 1'b0, 2'd1, 1'b0);
         else        apply(1'b1, 1'b1, 2'd3, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if ({step, wrap, idx, d} !== e) begin
            errors++;
            $display("FAIL mode_switch cycle %0d: got %b expected %b", i, {step, wrap, idx, d}, e);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [12:0] e;
      logic [2:0]  prev;
      logic [2:0]  k3;
      logic [7:0]  oh;
      repeat (2) apply(1'b1, 1'b1, 2'd0, 1'b0);
      prev = idx3;
      apply(1'b1, 1'b1, 2'd0, 1'b0);
      checks++;
      if (idx3 !== prev + 3'd1 || step3 !== 1'b1) begin
         errors++;
         $display("FAIL dwell1_advance: got idx=%0d step=%b expected idx=%0d step=1", idx3, step3, prev + 3'd1);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({step3, wrap3, idx3, d3} !== 13'h0) begin
         errors++;
         $display("FAIL async_reset_n3: got %b expected %b", {step3, wrap3, idx3, d3}, 13'h0);
      end
      checks++;
      if ({step, wrap, idx, d} !== 8'h00) begin
         errors++;
         $display("FAIL async_reset_main: got %b expected %b", {step, wrap, idx, d}, 8'h00);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp3_q.push_back({1'b0, 1'b0, 3'd0, 8'b0000_0001});
      for (int k = 1; k < 10; k++) begin
         k3 = k[2:0];
         oh = 8'b0000_0001 << k3;
         exp3_q.push_back({1'b1, (k3 == 3'd0), k3, oh});
      end
      for (int k = 0; k < 10; k++) begin
         apply(1'b1, 1'b1, 2'd0, 1'b0);
         e = exp3_q.pop_front();
         checks++;
         if ({step3, wrap3, idx3, d3} !== e) begin
            errors++;
            $display("FAIL scan_after_reset cycle %0d: got %b expected %b", k, {step3, wrap3, idx3, d3}, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_direct();
      test_scan_wrap();
      test_load_collide();
      test_enable_gap();
      test_mode_switch();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered N-to-2^N one-hot line decoder with enable and an auto-scan mode. In direct mode it registers an external select and drives exactly one output line. In scan mode it walks the output lines in sequence, holding each for a programmable number of cycles. It replaces the fixed 2-to-4 decoder wherever a decoded select must be timed, such as digit/row strobes for multiplexed displays and round-robin channel enables.

## Interface
- N, default 2: select width; output width is 2^N (N ≥ 1).
- DWELL, default 4: cycles each line stays active in scan mode (DWELL ≥ 1).
- ACTIVE_LOW, default 0: 1 inverts D, so the selected line is 0 and all others are 1.

- clk  in  1  rising-edge clock; the block uses one clock only.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  output enable; 0 forces all D lines inactive.
- mode  in  1  0 = direct decode of addr, 1 = auto-scan.
- addr  in  N  direct-mode select; in scan mode, the start index when load is high.
- load  in  1  scan mode only: set the index to addr and restart dwell.
- D  out  2^N  decoded lines; one-hot when active, all inactive otherwise.
- idx  out  N  current registered index.
- step  out  1  one-cycle pulse on the cycle after the scan index advances.
- wrap  out  1  one-cycle pulse when an advance goes from 2^N−1 to 0; coincides with step.

## Operation
- Registers:
  - idx (N bits).
  - dwell counter cnt (width clog2(DWELL), minimum 1 bit).
  - act (registered en).
  - step and wrap flags.
  - state (OFF, DIRECT, SCAN).
- State update on every edge:
  - en=0 → OFF.
  - en=1, mode=0 → DIRECT.
  - en=1, mode=1 → SCAN.
- OFF:
  - idx holds.
  - cnt is cleared.
  - step=wrap=0.
- DIRECT: idx ← addr, cnt ← 0, step=wrap=0.
- SCAN, in priority order:
  1. load=1: idx ← addr, cnt ← 0, no step.
  2. cnt = DWELL−1: idx ← idx+1 mod 2^N, cnt ← 0, step ← 1, wrap ← (idx = 2^N−1).
  3. Otherwise: cnt ← cnt+1, step=wrap=0.
- Entering SCAN from OFF or DIRECT:
  - idx is kept.
  - cnt starts at 0, because it was cleared in the previous state.
- DWELL = 1: idx advances on every SCAN edge, and step is high continuously.
- Output: D = act ? onehot(idx) : 0. When ACTIVE_LOW = 1, D is bitwise inverted.
- Invariant: when act=1, exactly one line of D is active, including at wrap boundaries. When act=0, no line is active.
- Index arithmetic is modulo 2^N. There is no overflow state.

## Timing
- Reset (rst_n low) acts immediately and asynchronously, including mid-scan. Values while in reset:
  - state = OFF, idx = 0, cnt = 0, act = 0, step = 0, wrap = 0.
  - D = all 0, or all 1 when ACTIVE_LOW = 1.
- After rst_n deasserts, the first active edge evaluates normally.
- Latency: addr, en and mode sampled at edge k are reflected on D, idx and step after edge k, which is 1 cycle.
- Scan period:
  - Each line stays active for DWELL cycles.
  - A full sweep takes DWELL·2^N cycles.
  - The first line after entering SCAN lasts DWELL cycles from the entry edge.
- load and a dwell expiry on the same edge: load wins, and step/wrap stay 0.
- en dropping mid-dwell: D goes inactive after that edge, cnt is cleared, and idx is retained.
- mode changing 1→0: on the next edge the block decodes addr, and any pending dwell is discarded.
- step and wrap never stay high longer than one cycle, except when DWELL = 1.

## Test plan
- Reset check: hold rst_n=0 with en=1 → D=0000, idx=0, step=0. Then release rst_n and apply en=1, mode=0, addr=2 → D=0100 after one edge.
- Direct sweep: N=2, en=1, mode=0, addr=0,1,2,3 on consecutive cycles → D=0001, 0010, 0100, 1000, each one cycle late. With ACTIVE_LOW=1 the same stimulus gives D=1110, 1101, 1011, 0111.
- Scan with wrap: N=2, DWELL=4, load addr=3 then scan → D=1000 for 4 cycles, then 0001. step and wrap pulse once, together, on the 3→0 transition. A full sweep takes 16 cycles.
- Load collides with expiry: in SCAN at cnt=3, assert load with addr=1 → idx=1, step=0, wrap=0. The next advance comes 4 cycles later.
- Enable gap: drop en for 2 cycles mid-dwell at idx=2 → D=0000 for those cycles. On re-enable D=0100 again and holds for a full DWELL.
- Async reset mid-scan: assert rst_n=0 between clock edges with N=3, DWELL=1 → D=0 and idx=0 immediately, without waiting for a clock edge. After release the scan resumes from 0.
